// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if: bus bundle between the cache miss/writeback paths,
// the arbiter and the RAM port.
//   master - arbiter view: takes icache/dcache requests and ram_ack/ramload,
//            drives waits, loads, RAM strobes/address/data and arb_err.
//   slave  - environment view (caches + RAM), the mirror image.
// Signals:
//   iREN/iaddr, iwait/iload                      icache request / response
//   dREN/dWEN/daddr/dstore/d_lock, dwait/dload   dcache request / response
//   ramREN/ramWEN/ramaddr/ramstore, ram_ack/ramload   RAM port
//   arb_err                                      watchdog abort pulse
interface cache_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              iwait;
   logic [DATA_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic              d_lock;
   logic              dwait;
   logic [DATA_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic              ram_ack;
   logic [DATA_W-1:0] ramload;
   logic              arb_err;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, d_lock, ram_ack, ramload,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, d_lock, ram_ack, ramload,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
   );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one word-wide RAM port between icache and dcache.
// One single-word transaction at a time: arbitrate in IDLE, hold the winner's
// request in a GRANT state until ram_ack or the watchdog fires, then return to
// IDLE for at least one cycle.
// Ports:
//   CLK   rising-edge clock
//   nRST  synchronous active-low reset
//   bus   cache_mem_arbiter_if.master (cache requests/responses, RAM port)
// Parameters: ADDR_W, DATA_W, TIMEOUT (watchdog limit in GRANT cycles, >= 1).
// Optional feature: define ARB_RR_EN for round-robin between the two caches;
// otherwise dcache has fixed priority. The dcache lock overrides both.
module cache_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                 CLK,
   input  logic                 nRST,
   cache_mem_arbiter_if.master  bus
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

   state_t           state, state_n;
   req_t             req_q, req_n;
   logic [CNT_W-1:0] cnt;
   logic             lock_q, lock_n;
   logic             d_req, i_req, pick_d, pick_i;
   logic             granted, at_limit, expired, done;

`ifdef ARB_RR_EN
   logic             last_d_q;   // 1 = dcache won the most recent grant
`endif

   // Eligibility: the lock flag shuts the icache out entirely.
   assign d_req = bus.dREN | bus.dWEN;
   assign i_req = bus.iREN & ~lock_q;

`ifdef ARB_RR_EN
   assign pick_d = d_req & (~i_req | ~last_d_q);
`else
   assign pick_d = d_req;
`endif
   assign pick_i = i_req & ~pick_d;

   assign granted  = (state != IDLE);
   assign at_limit = (cnt == CNT_W'(TIMEOUT));
   // ram_ack in the limit cycle still counts as a normal completion.
   assign expired  = granted & at_limit & ~bus.ram_ack;
   // A completion in a reset cycle is abandoned, so no wait-low escapes.
   assign done     = granted & nRST & (bus.ram_ack | at_limit);

   always_comb begin
      state_n      = state;
      req_n        = req_q;
      lock_n       = lock_q;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.iload    = '0;
      bus.dwait    = 1'b1;
      bus.dload    = '0;
      bus.arb_err  = 1'b0;

      case (state)
         IDLE: begin
            if (!bus.d_lock) lock_n = 1'b0;
            if (pick_d) begin
               state_n = DGRANT;
               req_n   = '{we: bus.dWEN, addr: bus.daddr, data: bus.dstore};
            end else if (pick_i) begin
               state_n = IGRANT;
               req_n   = '{we: 1'b0, addr: bus.iaddr, data: '0};
            end
         end
         IGRANT, DGRANT: begin
            // RAM side runs purely from the latched request.
            bus.ramREN  = ~req_q.we;
            bus.ramWEN  = req_q.we;
            bus.ramaddr = req_q.addr;
            if (req_q.we) bus.ramstore = req_q.data;
            if (done) begin
               state_n = IDLE;
               if (expired)
                  lock_n = 1'b0;
               else if (state == DGRANT && bus.d_lock)
                  lock_n = 1'b1;
               if (state == IGRANT) begin
                  bus.iwait = 1'b0;
                  if (bus.ram_ack) bus.iload = bus.ramload;
               end else begin
                  bus.dwait = 1'b0;
                  if (bus.ram_ack && !req_q.we) bus.dload = bus.ramload;
               end
               bus.arb_err = expired;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state  <= IDLE;
         req_q  <= '0;
         cnt    <= '0;
         lock_q <= 1'b0;
      end else begin
         state  <= state_n;
         req_q  <= req_n;
         lock_q <= lock_n;
         // Cleared while idle so every grant starts from zero; saturates.
         if (state == IDLE)
            cnt <= '0;
         else if (!bus.ram_ack && !at_limit)
            cnt <= cnt + CNT_W'(1);
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge CLK) begin
      if (!nRST)
         last_d_q <= 1'b1;
      else if (state == IDLE && (pick_d || pick_i))
         last_d_q <= pick_d;
   end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by a randomized
// run, all checked against a transaction-level reference model.
module tb_cache_mem_arbiter;
   localparam int TO = 4;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // RAM responder: 0 random acks, 1 ack after ram_dly strobe cycles,
   // 2 never ack, 3 ram_ack driven by hand.
   int          ram_mode = 1;
   int          ram_dly  = 2;
   int          scnt     = 0;
   logic [31:0] ram_val  = 32'h8C22_0004;

   task automatic tick();
      @(posedge CLK);
      #1;
      if (ram_mode != 3) begin
         if (bus.ramREN || bus.ramWEN) begin
            bus.ram_ack = (ram_mode == 0) ? ($urandom_range(0, 9) < 4)
                                          : (ram_mode == 1 && scnt == ram_dly);
            scnt++;
         end else begin
            scnt = 0;
            bus.ram_ack = (ram_mode == 0) ? ($urandom_range(0, 9) < 2) : 1'b0;
         end
         bus.ramload = (ram_mode == 1) ? ram_val : $urandom;
      end
   endtask

   // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache), the
   // captured request, how long it has waited, the lock and last winner.
   int          m_who = 0, m_age = 0, pick;
   logic        m_we = 0, m_lock = 0, m_last_d = 1;
   logic [31:0] m_addr = 0, m_data = 0;
   logic        e_ren, e_wen, e_iw, e_dw, e_err, fin, tmo, dreq, ireq;
   logic [31:0] e_il, e_dl, ld;
   bit          started = 0;
   bit          i_fin = 0, d_fin = 0;

   always @(posedge CLK) started <= 1'b1;

   always @(negedge CLK) begin
      if (started) begin
         e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_err = 0;
         e_il = 0; e_dl = 0; fin = 0; tmo = 0;
         if (m_who != 0) begin
            e_ren = !m_we;
            e_wen = m_we;
            fin   = nRST && (bus.ram_ack || m_age == TO);
            tmo   = nRST && !bus.ram_ack && m_age == TO;
            check("m_ramaddr", bus.ramaddr, m_addr);
            if (m_we) check("m_ramstore", bus.ramstore, m_data);
            if (fin) begin
               ld = (bus.ram_ack && !m_we) ? bus.ramload : 32'h0;
               if (m_who == 1) begin e_iw = 0; e_il = ld; end
               else            begin e_dw = 0; e_dl = ld; end
               e_err = tmo;
            end
         end
         check("m_ramREN", bus.ramREN, e_ren);
         check("m_ramWEN", bus.ramWEN, e_wen);
         check("m_iwait",  bus.iwait,  e_iw);
         check("m_iload",  bus.iload,  e_il);
         check("m_dwait",  bus.dwait,  e_dw);
         check("m_dload",  bus.dload,  e_dl);
         check("m_arb_err", bus.arb_err, e_err);
         i_fin = !e_iw;
         d_fin = !e_dw;

         // Advance to the state after the coming clock edge.
         if (!nRST) begin
            m_who = 0; m_age = 0; m_lock = 0; m_last_d = 1;
         end else if (m_who == 0) begin
            dreq = bus.dREN || bus.dWEN;
            ireq = bus.iREN && !m_lock;
            pick = 0;
            if (dreq && ireq) begin
`ifdef ARB_RR_EN
               pick = m_last_d ? 1 : 2;
`else
               pick = 2;
`endif
            end else if (dreq) pick = 2;
            else if (ireq)     pick = 1;
            if (!bus.d_lock) m_lock = 0;
            if (pick != 0) begin
               m_who = pick; m_age = 0; m_last_d = (pick == 2);
               m_we   = (pick == 2) ? bus.dWEN : 1'b0;
               m_addr = (pick == 2) ? bus.daddr : bus.iaddr;
               m_data = bus.dstore;
            end
         end else if (fin) begin
            if (tmo) m_lock = 0;
            else if (m_who == 2 && bus.d_lock) m_lock = 1;
            m_who = 0;
         end else if (m_age < TO) begin
            m_age++;
         end
      end
   end

   int r;

   initial begin
      bus.iREN = 1; bus.iaddr = 32'h100;
      bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0; bus.d_lock = 0;
      bus.ram_ack = 0; bus.ramload = 0;

      // Reset held two edges with a pending icache request.
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         check("rst_ramREN", bus.ramREN, 0);
         check("rst_ramWEN", bus.ramWEN, 0);
         check("rst_ramaddr", bus.ramaddr, 0);
         check("rst_ramstore", bus.ramstore, 0);
         check("rst_iwait", bus.iwait, 1);
         check("rst_dwait", bus.dwait, 1);
         check("rst_arb_err", bus.arb_err, 0);
         tick();
      end
      nRST = 1;

      // Icache read, RAM acks in the third strobe cycle.
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check("t2_ramREN", bus.ramREN, (c >= 1 && c <= 3));
         check("t2_iwait", bus.iwait, (c != 3));
         if (c == 3) check("t2_iload", bus.iload, 32'h8C22_0004);
         tick();
         if (c == 3) bus.iREN = 0;
      end

      // Simultaneous icache read and dcache write: dcache first.
      ram_dly = 0;
      bus.iREN = 1; bus.iaddr = 32'h140;
      bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check("t3_ramWEN", bus.ramWEN, (c == 1));
         check("t3_ramREN", bus.ramREN, (c == 3));
         if (c == 1) check("t3_ramstore", bus.ramstore, 32'hDEAD_BEEF);
         if (c == 3) check("t3_ramaddr", bus.ramaddr, 32'h140);
         check("t3_dwait", bus.dwait, (c != 1));
         check("t3_iwait", bus.iwait, (c != 3));
         tick();
         if (c == 1) bus.dWEN = 0;
         if (c == 3) bus.iREN = 0;
      end

      // Locked pair of dcache writes with icache waiting behind them.
      bus.d_lock = 1; bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = $urandom;
      bus.iREN = 1; bus.iaddr = 32'h180;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         if (c < 6) check("t4_iwait", bus.iwait, 1);
         check("t4_ramREN", bus.ramREN, (c == 6));
         check("t4_ramWEN", bus.ramWEN, (c == 1 || c == 3));
         if (c == 3) check("t4_ramaddr", bus.ramaddr, 32'h304);
         tick();
         if (c == 1) begin bus.daddr = 32'h304; bus.dstore = $urandom; end
         if (c == 3) begin bus.dWEN = 0; bus.d_lock = 0; end
         if (c == 6) bus.iREN = 0;
      end

      // Watchdog: RAM never answers a dcache read.
      ram_mode = 2;
      bus.dREN = 1; bus.daddr = 32'h400;
      for (int c = 0; c < 8; c++) begin
         @(negedge CLK);
         check("t5_arb_err", bus.arb_err, (c == 5));
         check("t5_dwait", bus.dwait, (c != 5));
         check("t5_dload", bus.dload, 0);
         check("t5_ramREN", bus.ramREN, (c >= 1 && c <= 5));
         tick();
         if (c == 5) bus.dREN = 0;
      end

      // Stray ack while idle, then reset in the middle of a dcache grant.
      ram_mode = 3;
      bus.ram_ack = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         check("t6_idle_iwait", bus.iwait, 1);
         check("t6_idle_dwait", bus.dwait, 1);
         tick();
      end
      bus.ram_ack = 0; bus.dREN = 1; bus.daddr = 32'h500;
      @(negedge CLK); tick();
      @(negedge CLK);
      check("t6_grant_ramREN", bus.ramREN, 1);
      tick();
      nRST = 0; bus.ram_ack = 1;
      @(negedge CLK);
      check("t6_rst_ramREN", bus.ramREN, 1);
      check("t6_rst_dwait", bus.dwait, 1);
      tick();
      nRST = 1; bus.ram_ack = 0; bus.dREN = 0;
      @(negedge CLK);
      check("t6_post_ramREN", bus.ramREN, 0);
      check("t6_post_dwait", bus.dwait, 1);
      tick();

      // Randomized traffic; requests are held until their wait drops.
      ram_mode = 0;
      for (int n = 0; n < 4000; n++) begin
         tick();
         nRST = ($urandom_range(0, 299) != 0);
         if (bus.iREN && i_fin) bus.iREN = 0;
         else if (!bus.iREN && $urandom_range(0, 2) == 0) begin
            bus.iREN = 1; bus.iaddr = $urandom;
         end
         if ((bus.dREN || bus.dWEN) && d_fin) begin
            bus.dREN = 0; bus.dWEN = 0;
         end else if (!(bus.dREN || bus.dWEN) && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3);
            bus.dWEN = (r == 1 || r == 2);
            bus.dREN = (r != 1);
            bus.daddr = $urandom; bus.dstore = $urandom;
         end
         if ($urandom_range(0, 7) == 0) bus.d_lock = ~bus.d_lock;
      end
      @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
